// File: rtl/tour_cmd_seq.sv
// Tour command sequencer for the Knight's Tour robot.
// While idle, UART commands pass straight through to cmd_proc. After start_tour the block
// takes the command port and replays the stored tour. Each knight move is sent as a vertical
// leg followed by a horizontal leg with fanfare.
`timescale 1ns/1ps
module tour_cmd_seq #(
  parameter int unsigned NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        clr_cmd_rdy_UART,
  output logic [7:0]  resp,
  output logic        tour_err
);

  // Command fields
  localparam logic [3:0] OpMove     = 4'h4;
  localparam logic [3:0] OpFanfare  = 4'h5;
  localparam logic [7:0] HeadNorth  = 8'h00;
  localparam logic [7:0] HeadWest   = 8'h3F;
  localparam logic [7:0] HeadSouth  = 8'h7F;
  localparam logic [7:0] HeadEast   = 8'hBF;

  // Response bytes
  localparam logic [7:0] RespFinal  = 8'hA5;
  localparam logic [7:0] RespAck    = 8'h5A;

  // Index of the last move of the tour
  localparam logic [4:0] LastIdx    = 5'(NUM_MOVES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StVert,
    StWaitV,
    StHorz,
    StWaitH
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  mv_indx_q, mv_indx_d;
  logic        tour_err_q, tour_err_d;

  // Decoded move: sign and magnitude of each leg
  logic        move_legal;
  logic        dx_pos;
  logic        dy_pos;
  logic [3:0]  dx_mag;
  logic [3:0]  dy_mag;
  logic [15:0] vert_leg;
  logic [15:0] horz_leg;
  logic        at_last;

  assign at_last = (mv_indx_q == LastIdx);

  // Decode the one-hot move word into (dx, dy); any other pattern is illegal
  always_comb begin
    move_legal = 1'b1;
    dx_pos     = 1'b1;
    dy_pos     = 1'b1;
    dx_mag     = 4'd0;
    dy_mag     = 4'd0;
    unique case (move)
      8'h01: begin dx_pos = 1'b1; dx_mag = 4'd1; dy_pos = 1'b1; dy_mag = 4'd2; end
      8'h02: begin dx_pos = 1'b0; dx_mag = 4'd1; dy_pos = 1'b1; dy_mag = 4'd2; end
      8'h04: begin dx_pos = 1'b0; dx_mag = 4'd2; dy_pos = 1'b1; dy_mag = 4'd1; end
      8'h08: begin dx_pos = 1'b0; dx_mag = 4'd2; dy_pos = 1'b0; dy_mag = 4'd1; end
      8'h10: begin dx_pos = 1'b0; dx_mag = 4'd1; dy_pos = 1'b0; dy_mag = 4'd2; end
      8'h20: begin dx_pos = 1'b1; dx_mag = 4'd1; dy_pos = 1'b0; dy_mag = 4'd2; end
      8'h40: begin dx_pos = 1'b1; dx_mag = 4'd2; dy_pos = 1'b0; dy_mag = 4'd1; end
      8'h80: begin dx_pos = 1'b1; dx_mag = 4'd2; dy_pos = 1'b1; dy_mag = 4'd1; end
      default: move_legal = 1'b0;
    endcase
  end

  // Build the two cmd_proc commands for the current move
  always_comb begin
    vert_leg = {OpMove, (dy_pos ? HeadNorth : HeadSouth), dy_mag};
    horz_leg = {OpFanfare, (dx_pos ? HeadEast : HeadWest), dx_mag};
  end

  // Next-state, index and sticky error logic
  always_comb begin
    state_d    = state_q;
    mv_indx_d  = mv_indx_q;
    tour_err_d = tour_err_q;
    unique case (state_q)
      StIdle: begin
        if (start_tour) begin
          state_d    = StVert;
          mv_indx_d  = 5'd0;
          tour_err_d = 1'b0;
        end
      end
      StVert: begin
        // A corrupt move word aborts the tour before any leg is offered
        if (!move_legal) begin
          tour_err_d = 1'b1;
          state_d    = StIdle;
        end else if (clr_cmd_rdy) begin
          state_d = StWaitV;
        end
      end
      StWaitV: begin
        if (send_resp) begin
          state_d = StHorz;
        end
      end
      StHorz: begin
        if (clr_cmd_rdy) begin
          state_d = StWaitH;
        end
      end
      StWaitH: begin
        if (send_resp) begin
          if (at_last) begin
            state_d = StIdle;
          end else begin
            mv_indx_d = mv_indx_q + 5'd1;
            state_d   = StVert;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Command port mux: UART passthrough when idle, tour legs otherwise
  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
      end
      StVert: begin
        cmd     = vert_leg;
        cmd_rdy = move_legal;
      end
      StWaitV: begin
        cmd = vert_leg;
      end
      StHorz: begin
        cmd     = horz_leg;
        cmd_rdy = 1'b1;
      end
      StWaitH: begin
        cmd = horz_leg;
      end
      default: begin
        cmd = cmd_UART;
      end
    endcase
  end

  // Intermediate legs are acked as non-final; the last move and idle report final
  always_comb begin
    resp = RespAck;
    if ((state_q == StIdle) || at_last) begin
      resp = RespFinal;
    end
  end

  // State, index and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mv_indx_q  <= 5'd0;
      tour_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mv_indx_q  <= mv_indx_d;
      tour_err_q <= tour_err_d;
    end
  end

  assign mv_indx  = mv_indx_q;
  assign tour_err = tour_err_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Self-checking bench for tour_cmd_seq: a tour memory model drives move, expected legs are
// queued when a tour is started and popped as the DUT offers each command.
`timescale 1ns/1ps
module tb_tour_cmd_seq;

  localparam int unsigned NumMoves = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_tour = 1'b0;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART = 16'h1234;
  logic        cmd_rdy_UART = 1'b0;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy_UART;
  logic [7:0]  resp;
  logic        tour_err;

  typedef struct packed {
    logic [15:0] cmd;
    logic [7:0]  resp;
    logic [4:0]  idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;

  // Tour memory controls
  bit         dir_mode = 1'b0;
  bit         err_en = 1'b0;
  logic [4:0] err_idx = 5'd0;
  logic [7:0] err_move = 8'h00;

  // Legal 5x5 knight's tour, as bit numbers of the one-hot move word
  int tour_bits [NumMoves] = '{7, 6, 1, 0, 3, 2, 5, 5, 7, 1, 2, 4,
                               5, 7, 0, 2, 3, 5, 6, 0, 1, 3, 4, 7};

  always #5 clk = ~clk;

  tour_cmd_seq #(
    .NUM_MOVES(NumMoves)
  ) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .resp             (resp),
    .tour_err         (tour_err)
  );

  function automatic int bit_of(input logic [4:0] idx, input bit dm);
    if (dm) return int'(idx) % 8;
    return tour_bits[idx];
  endfunction

  function automatic logic [7:0] move_of(input logic [4:0] idx, input bit dm, input bit ee,
                                         input logic [4:0] ei, input logic [7:0] em);
    logic [7:0] one;
    one = 8'h01;
    if (ee && (idx == ei)) return em;
    if (int'(idx) >= NumMoves) return 8'h00;
    return one << bit_of(idx, dm);
  endfunction

  // Combinational tour memory
  assign move = move_of(mv_indx, dir_mode, err_en, err_idx, err_move);

  // Reference command for one leg of a move given its bit number
  function automatic logic [15:0] exp_leg(input int b, input bit horz);
    int dx;
    int dy;
    logic [3:0] mag;
    case (b)
      0: begin dx =  1; dy =  2; end
      1: begin dx = -1; dy =  2; end
      2: begin dx = -2; dy =  1; end
      3: begin dx = -2; dy = -1; end
      4: begin dx = -1; dy = -2; end
      5: begin dx =  1; dy = -2; end
      6: begin dx =  2; dy = -1; end
      default: begin dx = 2; dy = 1; end
    endcase
    if (horz) begin
      mag = 4'((dx < 0) ? -dx : dx);
      return {4'h5, ((dx > 0) ? 8'hBF : 8'h3F), mag};
    end
    mag = 4'((dy < 0) ? -dy : dy);
    return {4'h4, ((dy > 0) ? 8'h00 : 8'h7F), mag};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Queue both legs of moves 0..count-1
  task automatic push_tour(input int count, input bit dm);
    exp_t e;
    int   b;
    for (int i = 0; i < count; i++) begin
      b      = bit_of(5'(i), dm);
      e.idx  = 5'(i);
      e.resp = (i == NumMoves - 1) ? 8'hA5 : 8'h5A;
      e.cmd  = exp_leg(b, 1'b0);
      exp_q.push_back(e);
      e.cmd  = exp_leg(b, 1'b1);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input int count, input bit dm);
    push_tour(count, dm);
    start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
    check_eq("start_rdy", 32'(cmd_rdy), 32'd1);
  endtask

  // Act as cmd_proc for one leg; optional same-cycle clr/send, start poke, and withheld resp
  task automatic run_leg(input bit both, input bit poke, input bit skip_resp);
    exp_t e;
    int   w;
    w = 0;
    while (!cmd_rdy && (w < 20)) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_rdy) begin
      check_eq("rdy_timeout", 32'd0, 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check_eq("cmd", 32'(cmd), 32'(e.cmd));
    check_eq("resp", 32'(resp), 32'(e.resp));
    check_eq("mv_indx", 32'(mv_indx), 32'(e.idx));
    check_eq("clr_uart_blk", 32'(clr_cmd_rdy_UART), 32'd0);
    // send_resp while a leg is offered must be ignored
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    check_eq("hold_cmd", 32'(cmd), 32'(e.cmd));
    check_eq("hold_rdy", 32'(cmd_rdy), 32'd1);
    clr_cmd_rdy = 1'b1;
    send_resp   = both;
    #1;
    check_eq("clr_uart_blk", 32'(clr_cmd_rdy_UART), 32'd0);
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    check_eq("wait_rdy", 32'(cmd_rdy), 32'd0);
    check_eq("wait_resp", 32'(resp), 32'(e.resp));
    if (both) begin
      @(negedge clk);
      check_eq("drop_resp", 32'(cmd_rdy), 32'd0);
    end
    if (poke) begin
      start_tour = 1'b1;
      @(negedge clk);
      start_tour = 1'b0;
      check_eq("poke_idx", 32'(mv_indx), 32'(e.idx));
    end
    if (!skip_resp) begin
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check_eq("rst_idx", 32'(mv_indx), 32'd0);
    check_eq("rst_err", 32'(tour_err), 32'd0);
    check_eq("rst_resp", 32'(resp), 32'hA5);
    check_eq("rst_cmd", 32'(cmd), 32'h1234);
    check_eq("rst_rdy", 32'(cmd_rdy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // UART passthrough
    cmd_UART     = 16'h2000;
    cmd_rdy_UART = 1'b1;
    clr_cmd_rdy  = 1'b1;
    #1;
    check_eq("pt_cmd", 32'(cmd), 32'h2000);
    check_eq("pt_rdy", 32'(cmd_rdy), 32'd1);
    check_eq("pt_clr", 32'(clr_cmd_rdy_UART), 32'd1);
    check_eq("pt_resp", 32'(resp), 32'hA5);
    @(negedge clk);
    clr_cmd_rdy  = 1'b0;
    cmd_rdy_UART = 1'b0;

    // All eight directions cycled over a full-length tour, with a UART command pending
    dir_mode     = 1'b1;
    cmd_UART     = 16'hDEAD;
    cmd_rdy_UART = 1'b1;
    do_start(NumMoves, 1'b1);
    for (int i = 0; i < 2 * NumMoves; i++) begin
      run_leg((i % 5) == 1, (i % 3) == 0, 1'b0);
    end
    check_eq("sb_left", 32'(exp_q.size()), 32'd0);
    check_eq("end_cmd", 32'(cmd), 32'hDEAD);
    check_eq("end_rdy", 32'(cmd_rdy), 32'd1);
    check_eq("end_resp", 32'(resp), 32'hA5);
    cmd_rdy_UART = 1'b0;
    @(negedge clk);

    // Legal knight's tour, then passthrough restored
    dir_mode = 1'b0;
    do_start(NumMoves, 1'b0);
    for (int i = 0; i < 2 * NumMoves; i++) begin
      run_leg(1'b0, i == 10, 1'b0);
    end
    check_eq("sb_left", 32'(exp_q.size()), 32'd0);
    cmd_UART     = 16'h3456;
    cmd_rdy_UART = 1'b1;
    clr_cmd_rdy  = 1'b1;
    #1;
    check_eq("pt2_cmd", 32'(cmd), 32'h3456);
    check_eq("pt2_rdy", 32'(cmd_rdy), 32'd1);
    check_eq("pt2_clr", 32'(clr_cmd_rdy_UART), 32'd1);
    @(negedge clk);
    clr_cmd_rdy  = 1'b0;
    cmd_rdy_UART = 1'b0;

    // Illegal move word at index 5
    err_en   = 1'b1;
    err_idx  = 5'd5;
    err_move = 8'h03;
    do_start(5, 1'b0);
    for (int i = 0; i < 10; i++) begin
      run_leg(1'b0, 1'b0, 1'b0);
    end
    check_eq("err_no_cmd", 32'(cmd_rdy), 32'd0);
    check_eq("err_idx", 32'(mv_indx), 32'd5);
    @(negedge clk);
    check_eq("err_set", 32'(tour_err), 32'd1);
    check_eq("err_resp", 32'(resp), 32'hA5);
    cmd_rdy_UART = 1'b1;
    #1;
    check_eq("err_idle", 32'(cmd_rdy), 32'd1);
    cmd_rdy_UART = 1'b0;
    @(negedge clk);
    check_eq("err_sticky", 32'(tour_err), 32'd1);
    err_en = 1'b0;

    // Restart clears the error; reset while waiting in WAIT_H at index 10
    do_start(NumMoves, 1'b0);
    check_eq("err_clr", 32'(tour_err), 32'd0);
    for (int i = 0; i < 21; i++) begin
      run_leg(1'b0, 1'b0, 1'b0);
    end
    run_leg(1'b0, 1'b0, 1'b1);
    check_eq("pre_rst_idx", 32'(mv_indx), 32'd10);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_idx", 32'(mv_indx), 32'd0);
    check_eq("mid_rst_err", 32'(tour_err), 32'd0);
    check_eq("mid_rst_rdy", 32'(cmd_rdy), 32'd0);
    check_eq("mid_rst_resp", 32'(resp), 32'hA5);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_rdy", 32'(cmd_rdy), 32'd0);
    check_eq("post_rst_idx", 32'(mv_indx), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
